// File: rtl/bus_arb_wdt.sv
// Round-robin arbiter for four masters with hold-limit preemption and a slave-ready watchdog.
// A stalled transfer is terminated with a forced ready and a one-cycle bus error pulse.
module bus_arb_wdt #(
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8,
    parameter int MAX_HOLD   = 64,
    parameter int HOLD_WIDTH = 7
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    input  logic       sAs_,
    input  logic       mRdy_,
    output logic       toRdy_,
    output logic       busErr,
    output logic [1:0] errMaster,
    output logic [7:0] errCnt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, ERR} state_t;

    state_t                state, state_next;
    logic [1:0]            owner, owner_next;
    logic [1:0]            last_owner, last_owner_next;
    logic [1:0]            err_master, err_master_next;
    logic [7:0]            err_cnt, err_cnt_next;
    logic [TO_WIDTH-1:0]   wd_cnt, wd_next;
    logic [HOLD_WIDTH-1:0] hold_cnt, hold_next;

    logic [3:0] req;
    logic       own_req;
    logic       other_req;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;

    assign req       = ~{m3Req_, m2Req_, m1Req_, m0Req_};
    assign own_req   = req[owner];
    assign other_req = |(req & ~(4'b0001 << owner));

    // Search starts just after the previous owner so every master gets a turn.
    always_comb begin
        pick  = last_owner;
        found = 1'b0;
        cand  = last_owner;
        for (int i = 1; i <= 4; i++) begin
            cand = last_owner + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd3;
            err_master <= 2'd0;
            err_cnt    <= 8'd0;
            wd_cnt     <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            err_master <= err_master_next;
            err_cnt    <= err_cnt_next;
            wd_cnt     <= wd_next;
            hold_cnt   <= hold_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        err_master_next = err_master;
        err_cnt_next    = err_cnt;
        wd_next         = wd_cnt;
        hold_next       = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    owner_next = pick;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (!sAs_) begin
                    state_next = XFER;
                    wd_next    = '0;
                end else if (!own_req) begin
                    state_next      = IDLE;
                    last_owner_next = owner;
                end else if (other_req) begin
                    if (hold_cnt == HOLD_WIDTH'(MAX_HOLD - 1)) begin
                        state_next      = IDLE;
                        last_owner_next = owner;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end else begin
                    hold_next = '0;
                end
            end
            XFER: begin
                // Ready takes precedence over an expiring watchdog in the same cycle.
                if (!mRdy_) begin
                    state_next = GRANT;
                    wd_next    = '0;
                end else if (wd_cnt == TO_WIDTH'(TIMEOUT - 1)) begin
                    state_next      = ERR;
                    err_master_next = owner;
                    err_cnt_next    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                end else begin
                    wd_next = wd_cnt + 1'b1;
                end
            end
            ERR: begin
                state_next      = IDLE;
                last_owner_next = owner;
                wd_next         = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign m0Grnt_   = !(busy && owner == 2'd0);
    assign m1Grnt_   = !(busy && owner == 2'd1);
    assign m2Grnt_   = !(busy && owner == 2'd2);
    assign m3Grnt_   = !(busy && owner == 2'd3);
    assign busErr    = (state == ERR);
    assign toRdy_    = !(state == ERR);
    assign errMaster = err_master;
    assign errCnt    = err_cnt;

endmodule

// File: tb/tb_bus_arb_wdt.sv
// Directed bench for bus_arb_wdt with TIMEOUT=4 and MAX_HOLD=3.
module tb_bus_arb_wdt;

    logic       clk;
    logic       reset_;
    logic [3:0] req;
    logic       sAs_;
    logic       mRdy_;
    logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
    logic       toRdy_;
    logic       busErr;
    logic [1:0] errMaster;
    logic [7:0] errCnt;
    logic       busy;
    logic [3:0] grnt;

    int passed;
    int total;

    assign grnt = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};

    bus_arb_wdt #(
        .TIMEOUT(4), .TO_WIDTH(8), .MAX_HOLD(3), .HOLD_WIDTH(7)
    ) dut (
        .clk(clk), .reset_(reset_),
        .m0Req_(req[0]), .m1Req_(req[1]), .m2Req_(req[2]), .m3Req_(req[3]),
        .m0Grnt_(m0Grnt_), .m1Grnt_(m1Grnt_), .m2Grnt_(m2Grnt_), .m3Grnt_(m3Grnt_),
        .sAs_(sAs_), .mRdy_(mRdy_), .toRdy_(toRdy_), .busErr(busErr),
        .errMaster(errMaster), .errCnt(errCnt), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_ = 1'b0;
        req    = 4'b1111;
        sAs_   = 1'b1;
        mRdy_  = 1'b1;
        step();
        step();
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        req    = 4'b1110;
        sAs_   = 1'b1;
        mRdy_  = 1'b1;
        step();
        step();
        total++; if (grnt !== 4'b1111) $display("FAIL reset_grants: got %b want 1111", grnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (toRdy_ !== 1'b1 || busErr !== 1'b0) $display("FAIL reset_err: toRdy_=%b busErr=%b want 1/0", toRdy_, busErr); else passed++;
        total++; if (errCnt !== 8'd0 || errMaster !== 2'd0) $display("FAIL reset_cnt: errCnt=%0d errMaster=%0d want 0/0", errCnt, errMaster); else passed++;
        reset_ = 1'b1;
        step();
        total++; if (grnt !== 4'b1110) $display("FAIL first_grant: got %b want 1110", grnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy); else passed++;
        req = 4'b1111;
        step();
        total++; if (grnt !== 4'b1111 || busy !== 1'b0) $display("FAIL release: grnt=%b busy=%b want 1111/0", grnt, busy); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        apply_reset();
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            want = ~(4'b0001 << (k % 4));
            step();
            total++; if (grnt !== want) $display("FAIL rr_grant%0d: got %b want %b", k, grnt, want); else passed++;
            sAs_ = 1'b0;
            step();
            sAs_  = 1'b1;
            mRdy_ = 1'b0;
            step();
            mRdy_ = 1'b1;
            req[k % 4] = 1'b1;
            step();
            total++; if (grnt !== 4'b1111) $display("FAIL rr_turnaround%0d: got %b want 1111", k, grnt); else passed++;
            req = 4'b0000;
        end
        req = 4'b1111;
        step();
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 4'b1101;
        step();
        total++; if (grnt !== 4'b1101) $display("FAIL to_grant: got %b want 1101", grnt); else passed++;
        sAs_ = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            total++; if (busErr !== 1'b0 || toRdy_ !== 1'b1 || grnt !== 4'b1101) $display("FAIL to_xfer%0d: busErr=%b toRdy_=%b grnt=%b want 0/1/1101", c, busErr, toRdy_, grnt); else passed++;
            if (c < 3) step();
        end
        sAs_ = 1'b1;
        req  = 4'b1111;
        step();
        total++; if (busErr !== 1'b1 || toRdy_ !== 1'b0) $display("FAIL to_err: busErr=%b toRdy_=%b want 1/0", busErr, toRdy_); else passed++;
        total++; if (errMaster !== 2'd1) $display("FAIL to_errmaster: got %0d want 1", errMaster); else passed++;
        step();
        total++; if (grnt !== 4'b1111 || busErr !== 1'b0 || toRdy_ !== 1'b1) $display("FAIL to_after: grnt=%b busErr=%b toRdy_=%b want 1111/0/1", grnt, busErr, toRdy_); else passed++;
        total++; if (errCnt !== 8'd1 || errMaster !== 2'd1) $display("FAIL to_cnt: errCnt=%0d errMaster=%0d want 1/1", errCnt, errMaster); else passed++;
    endtask

    task automatic test_ready_wins();
        req = 4'b1101;
        step();
        sAs_ = 1'b0;
        step();
        sAs_ = 1'b1;
        step();
        step();
        step();
        mRdy_ = 1'b0;
        step();
        mRdy_ = 1'b1;
        total++; if (busErr !== 1'b0 || grnt !== 4'b1101) $display("FAIL rw_grant: busErr=%b grnt=%b want 0/1101", busErr, grnt); else passed++;
        req = 4'b1111;
        step();
        total++; if (busErr !== 1'b0 || grnt !== 4'b1111) $display("FAIL rw_idle: busErr=%b grnt=%b want 0/1111", busErr, grnt); else passed++;
        total++; if (errCnt !== 8'd1) $display("FAIL rw_cnt: got %0d want 1", errCnt); else passed++;
    endtask

    task automatic test_preempt();
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (grnt !== 4'b1011) $display("FAIL pre_hold%0d: got %b want 1011", c, grnt); else passed++;
        end
        step();
        total++; if (grnt !== 4'b1111) $display("FAIL pre_idle: got %b want 1111", grnt); else passed++;
        step();
        total++; if (grnt !== 4'b0111) $display("FAIL pre_next: got %b want 0111", grnt); else passed++;
        req = 4'b1111;
        step();
        req = 4'b0011;
        step();
        step();
        sAs_ = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            sAs_ = 1'b1;
            total++; if (grnt !== 4'b1011) $display("FAIL pre_xfer%0d: got %b want 1011", c, grnt); else passed++;
        end
        mRdy_ = 1'b0;
        step();
        mRdy_ = 1'b1;
        total++; if (grnt !== 4'b1011) $display("FAIL pre_back: got %b want 1011", grnt); else passed++;
        step();
        total++; if (grnt !== 4'b1011) $display("FAIL pre_last: got %b want 1011", grnt); else passed++;
        step();
        total++; if (grnt !== 4'b1111) $display("FAIL pre_idle2: got %b want 1111", grnt); else passed++;
        step();
        total++; if (grnt !== 4'b0111) $display("FAIL pre_next2: got %b want 0111", grnt); else passed++;
        req = 4'b1111;
        step();
    endtask

    task automatic test_saturate();
        int  want_cnt;
        bit  seen;
        want_cnt = 1;
        req  = 4'b1110;
        sAs_ = 1'b0;
        for (int n = 0; n < 300; n++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (busErr === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                total++;
                $display("FAIL sat_wait%0d: busErr=%b want 1 within 20 cycles", n, busErr);
                break;
            end
            step();
            want_cnt = (want_cnt < 255) ? want_cnt + 1 : 255;
            if (want_cnt == 254 || n == 299) begin
                total++; if (errCnt !== 8'(want_cnt)) $display("FAIL sat_cnt%0d: got %0d want %0d", n, errCnt, want_cnt); else passed++;
            end
        end
        total++; if (errMaster !== 2'd0) $display("FAIL sat_master: got %0d want 0", errMaster); else passed++;
        step();
        step();
        total++; if (grnt !== 4'b1110) $display("FAIL sat_xfer: got %b want 1110", grnt); else passed++;
        reset_ = 1'b0;
        #1;
        total++; if (grnt !== 4'b1111 || busy !== 1'b0) $display("FAIL midreset_grant: grnt=%b busy=%b want 1111/0", grnt, busy); else passed++;
        total++; if (errCnt !== 8'd0) $display("FAIL midreset_cnt: got %0d want 0", errCnt); else passed++;
        step();
        step();
        total++; if (busErr !== 1'b0 || toRdy_ !== 1'b1) $display("FAIL midreset_err: busErr=%b toRdy_=%b want 0/1", busErr, toRdy_); else passed++;
        req    = 4'b1111;
        sAs_   = 1'b1;
        reset_ = 1'b1;
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_ready_wins();
        test_preempt();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
